// File: rtl/contador_ctrl_if.sv
// Request/feedback bundle between the board push-buttons, the lab counter
// and the contador_ctrl sequencer. The slave side is the controller.
interface contador_ctrl_if #(
    parameter int N     = 8,
    parameter int DIV_W = 24
);
    logic             start_i;
    logic             stop_i;
    logic             clear_i;
    logic             step_i;
    logic [DIV_W-1:0] div_i;
    logic [N-1:0]     limit_i;
    logic [N-1:0]     q_i;
    logic             en_o;
    logic             clr_no;
    logic             running_o;
    logic             done_o;
    logic             wrap_o;

    modport master (
        output start_i, stop_i, clear_i, step_i, div_i, limit_i, q_i,
        input  en_o, clr_no, running_o, done_o, wrap_o
    );

    modport slave (
        input  start_i, stop_i, clear_i, step_i, div_i, limit_i, q_i,
        output en_o, clr_no, running_o, done_o, wrap_o
    );
endinterface

// File: rtl/contador_ctrl.sv
// Sequencing controller for the Laboratorio 2 up-counter. Push-button
// levels are synchronized and edge-detected into single events, which
// drive an IDLE/RUN/PAUSE/DONE machine producing a prescaled counter
// enable, a one-cycle active-low counter clear and stop-at-limit.
// SYNC_STAGES must be at least 2.
module contador_ctrl #(
    parameter int N           = 8,
    parameter int DIV_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    contador_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;

    // Request bit order everywhere below: {clear, stop, start, step}
    logic [SYNC_STAGES-1:0][3:0] sync_chain;
    logic [3:0]                  req_sync;
    logic [3:0]                  req_prev;
    logic                        clear_evt;
    logic                        stop_evt;
    logic                        start_evt;
    logic                        step_evt;

    logic [DIV_W-1:0]            div_cnt;
    logic                        tick;
    logic                        at_limit;
    logic                        prescale_clear;
    logic                        step_accept;
    logic                        step_pulse;
    logic                        clr_n;
    logic                        wrap_q;
    logic                        en;

    assign req_sync = sync_chain[SYNC_STAGES-1];
    assign {clear_evt, stop_evt, start_evt, step_evt} = req_sync & ~req_prev;

    // A zero limit means free-run, so only a non-zero limit can stop the count
    assign at_limit = (bus.limit_i != '0) && (bus.q_i == bus.limit_i);
    assign tick     = (div_cnt >= bus.div_i);

    // Clock-domain crossing chain plus the previous-value register for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_chain <= '0;
            req_prev   <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0],
                           {bus.clear_i, bus.stop_i, bus.start_i, bus.step_i}};
            req_prev   <= req_sync;
        end
    end

    // Next-state selection; clear beats everything, and within a state the
    // highest-priority event present swallows the lower ones
    always_comb begin
        state_next     = state;
        prescale_clear = 1'b0;
        step_accept    = 1'b0;
        if (clear_evt) begin
            state_next     = IDLE;
            prescale_clear = 1'b1;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (!stop_evt) begin
                        if (start_evt) begin
                            state_next     = RUN;
                            prescale_clear = 1'b1;
                        end else if (step_evt && !at_limit) begin
                            step_accept = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop_evt) begin
                        state_next = PAUSE;
                    end else if (at_limit) begin
                        state_next = DONE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Prescaler only advances while running and restarts from zero on every entry into RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (prescale_clear || (state != RUN) || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // State register and the registered single-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            step_pulse <= 1'b0;
            clr_n      <= 1'b1;
            wrap_q     <= 1'b0;
        end else begin
            state      <= state_next;
            step_pulse <= step_accept;
            clr_n      <= ~clear_evt;
            wrap_q     <= en && (bus.q_i == '1);
        end
    end

    // The enable stays low while the counter is being cleared
    assign en = clr_n && (((state == RUN) && tick && !at_limit) || step_pulse);

    assign bus.en_o      = en;
    assign bus.clr_no    = clr_n;
    assign bus.running_o = (state == RUN);
    assign bus.done_o    = (state == DONE);
    assign bus.wrap_o    = wrap_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: a behavioural counter closes the Q loop, and a
// reference model built from input-level history, a run-phase count and a
// mode number predicts every output and the counter value each cycle.
`timescale 1ns/1ps
module tb_contador_ctrl;

    localparam int N       = 8;
    localparam int DIV_W   = 24;
    localparam int S       = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #50 clk = ~clk;

    contador_ctrl_if #(.N(N), .DIV_W(DIV_W)) bus ();

    contador_ctrl #(.N(N), .DIV_W(DIV_W), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Lab counter: cleared by reset ANDed with clr_no, counts on EN
    logic [N-1:0] cnt_q;
    logic         cnt_rst_n;
    assign cnt_rst_n = rst & bus.clr_no;
    assign bus.q_i   = cnt_q;

    always @(posedge clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n) cnt_q <= '0;
        else if (bus.en_o) cnt_q <= cnt_q + 8'd1;
    end

    // Reference model state
    int           m_mode;
    int           m_phase;
    logic         m_step;
    logic         m_clr;
    logic         m_wrap;
    logic [N-1:0] mq;
    logic [3:0]   h [0:S];
    logic [3:0]   m_ev;
    logic         lim_hit;
    logic         m_tick;
    logic         exp_en;
    logic [12:0]  exp_vec;
    logic [12:0]  obs_vec;

    // A press is seen S edges after its first sample, as a rise between consecutive samples
    assign m_ev    = h[S-1] & ~h[S];
    assign lim_hit = (bus.limit_i != 0) && (mq == bus.limit_i);
    assign m_tick  = ((m_phase % (int'(bus.div_i) + 1)) == int'(bus.div_i));
    assign exp_en  = !m_clr && (((m_mode == M_RUN) && m_tick && !lim_hit) || m_step);
    assign exp_vec = {exp_en, !m_clr, m_mode == M_RUN, m_mode == M_DONE, m_wrap, mq};
    assign obs_vec = {bus.en_o, bus.clr_no, bus.running_o, bus.done_o, bus.wrap_o, cnt_q};

    // Model update once per clock, reset asynchronously like the board reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  <= M_IDLE;
            m_phase <= 0;
            m_step  <= 1'b0;
            m_clr   <= 1'b0;
            m_wrap  <= 1'b0;
            mq      <= '0;
            for (int k = 0; k <= S; k++) h[k] <= '0;
        end else begin
            h[0] <= {bus.clear_i, bus.stop_i, bus.start_i, bus.step_i};
            for (int k = 1; k <= S; k++) h[k] <= h[k-1];
            m_wrap <= exp_en && (mq == 8'hFF);
            m_step <= 1'b0;
            m_clr  <= 1'b0;
            mq     <= exp_en ? mq + 8'd1 : mq;
            if (m_ev[3]) begin
                m_mode <= M_IDLE;
                m_clr  <= 1'b1;
                mq     <= '0;
            end else begin
                case (m_mode)
                    M_IDLE, M_PAUSE: begin
                        if (!m_ev[2]) begin
                            if (m_ev[1]) begin
                                m_mode  <= M_RUN;
                                m_phase <= 0;
                            end else if (m_ev[0] && !lim_hit) begin
                                m_step <= 1'b1;
                            end
                        end
                    end
                    M_RUN: begin
                        m_phase <= m_phase + 1;
                        if (m_ev[2]) m_mode <= M_PAUSE;
                        else if (lim_hit) m_mode <= M_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.en_o !== 1'b0) begin fails++; $display("FAIL reset_en: observed %b expected 0", bus.en_o); end
        checks++;
        if (bus.clr_no !== 1'b1) begin fails++; $display("FAIL reset_clr_n: observed %b expected 1", bus.clr_no); end
        checks++;
        if (bus.running_o !== 1'b0) begin fails++; $display("FAIL reset_running: observed %b expected 0", bus.running_o); end
        checks++;
        if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done: observed %b expected 0", bus.done_o); end
        checks++;
        if (bus.wrap_o !== 1'b0) begin fails++; $display("FAIL reset_wrap: observed %b expected 0", bus.wrap_o); end
        checks++;
        if (obs_vec !== exp_vec) begin fails++; $display("FAIL reset_model: observed %h expected %h", obs_vec, exp_vec); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prescaled_run();
        int en_count = 0;
        bus.div_i   = 24'd3;
        bus.limit_i = 8'd0;
        bus.start_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        checks++;
        if (bus.running_o !== 1'b0) begin fails++; $display("FAIL start_edge2: observed %b expected 0", bus.running_o); end
        @(negedge clk);
        checks++;
        if (bus.running_o !== 1'b1) begin fails++; $display("FAIL start_edge3: observed %b expected 1", bus.running_o); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL prescaled_model: observed %h expected %h at %0t", obs_vec, exp_vec, $time); end
            if (bus.en_o) en_count++;
        end
        checks++;
        if (en_count != 10) begin fails++; $display("FAIL prescaled_pulses: observed %0d expected 10", en_count); end
        checks++;
        if (cnt_q !== 8'd10) begin fails++; $display("FAIL prescaled_q: observed %0d expected 10", cnt_q); end
    endtask

    task automatic test_pause_step();
        int en_count = 0;
        logic [N-1:0] q_hold;
        bus.stop_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.stop_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL stop_model: observed %h expected %h", obs_vec, exp_vec); end
        end
        checks++;
        if (bus.running_o !== 1'b0) begin fails++; $display("FAIL pause_running: observed %b expected 0", bus.running_o); end
        q_hold = mq;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.en_o) en_count++;
        end
        checks++;
        if (en_count != 0) begin fails++; $display("FAIL pause_en: observed %0d pulses expected 0", en_count); end
        checks++;
        if (cnt_q !== q_hold) begin fails++; $display("FAIL pause_hold: observed %0d expected %0d", cnt_q, q_hold); end
        for (int p = 0; p < 2; p++) begin
            bus.step_i = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                bus.step_i = 1'b0;
                checks++;
                if (obs_vec !== exp_vec) begin fails++; $display("FAIL step_model: observed %h expected %h", obs_vec, exp_vec); end
                if (bus.en_o) en_count++;
            end
        end
        checks++;
        if (en_count != 2) begin fails++; $display("FAIL step_pulses: observed %0d expected 2", en_count); end
        checks++;
        if (cnt_q !== q_hold + 8'd2) begin fails++; $display("FAIL step_q: observed %0d expected %0d", cnt_q, q_hold + 8'd2); end
        en_count = 0;
        bus.start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        checks++;
        if (bus.running_o !== 1'b1) begin fails++; $display("FAIL resume_running: observed %b expected 1", bus.running_o); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL resume_model: observed %h expected %h", obs_vec, exp_vec); end
            if (bus.en_o) en_count++;
        end
        checks++;
        if (en_count != 2) begin fails++; $display("FAIL resume_pulses: observed %0d expected 2", en_count); end
    endtask

    task automatic test_limit_done();
        int en_count = 0;
        int clr_low  = 0;
        bus.clear_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.clear_i = 1'b0;
        end
        checks++;
        if ({bus.running_o, cnt_q} !== 9'd0) begin fails++; $display("FAIL limit_pre_clear: observed %h expected 000", {bus.running_o, cnt_q}); end
        bus.div_i   = 24'd0;
        bus.limit_i = 8'd10;
        bus.start_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL limit_model: observed %h expected %h", obs_vec, exp_vec); end
        end
        checks++;
        if (bus.done_o !== 1'b1) begin fails++; $display("FAIL limit_done: observed %b expected 1", bus.done_o); end
        checks++;
        if (cnt_q !== 8'd10) begin fails++; $display("FAIL limit_q: observed %0d expected 10", cnt_q); end
        bus.start_i = 1'b1;
        bus.step_i  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.step_i  = 1'b0;
            if (bus.en_o) en_count++;
        end
        checks++;
        if (en_count != 0 || bus.done_o !== 1'b1 || cnt_q !== 8'd10) begin
            fails++;
            $display("FAIL done_ignore: observed en=%0d done=%b q=%0d expected en=0 done=1 q=10", en_count, bus.done_o, cnt_q);
        end
        bus.clear_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.clear_i = 1'b0;
            if (!bus.clr_no) clr_low++;
        end
        checks++;
        if (clr_low != 1) begin fails++; $display("FAIL done_clear_pulse: observed %0d low cycles expected 1", clr_low); end
        checks++;
        if ({bus.done_o, bus.running_o, cnt_q} !== 10'd0) begin
            fails++;
            $display("FAIL done_clear_state: observed %h expected 000", {bus.done_o, bus.running_o, cnt_q});
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        bus.div_i   = 24'd0;
        bus.limit_i = 8'd0;
        bus.start_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL wrap_model: observed %h expected %h at %0t", obs_vec, exp_vec, $time); end
            if (bus.wrap_o) wraps++;
        end
        checks++;
        if (wraps != 1) begin fails++; $display("FAIL wrap_count: observed %0d expected 1", wraps); end
        bus.clear_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.clear_i = 1'b0;
        end
    endtask

    task automatic test_clear_start_same();
        int clr_low = 0;
        int en_count = 0;
        int run_count = 0;
        bus.start_i = 1'b1;
        bus.clear_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.clear_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL clear_start_model: observed %h expected %h", obs_vec, exp_vec); end
            if (!bus.clr_no) clr_low++;
            if (bus.en_o) en_count++;
            if (bus.running_o) run_count++;
        end
        checks++;
        if (clr_low != 1 || en_count != 0 || run_count != 0) begin
            fails++;
            $display("FAIL clear_wins: observed clr=%0d en=%0d run=%0d expected 1 0 0", clr_low, en_count, run_count);
        end
    endtask

    task automatic test_mid_run_reset();
        int run_count = 0;
        bus.div_i   = 24'd1;
        bus.start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        @(posedge clk);
        #30;
        rst = 1'b0;
        bus.start_i = 1'b1;
        #1;
        checks++;
        if (obs_vec !== 13'b0_1_0_0_0_00000000) begin fails++; $display("FAIL async_reset: observed %h expected 800", obs_vec); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL held_start_model: observed %h expected %h", obs_vec, exp_vec); end
        end
        checks++;
        if (bus.running_o !== 1'b1) begin fails++; $display("FAIL held_start_run: observed %b expected 1", bus.running_o); end
        bus.stop_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.stop_i = 1'b0;
            if (i >= 5 && bus.running_o) run_count++;
        end
        checks++;
        if (run_count != 0) begin fails++; $display("FAIL held_start_once: observed %0d running cycles expected 0", run_count); end
        bus.start_i = 1'b0;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 6; seg++) begin
            {bus.clear_i, bus.stop_i, bus.start_i, bus.step_i} = 4'b0000;
            repeat (2) @(negedge clk);
            bus.clear_i = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                bus.clear_i = 1'b0;
            end
            bus.div_i   = 24'($urandom_range(0, 3));
            bus.limit_i = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
            for (int i = 0; i < 250; i++) begin
                @(negedge clk);
                checks++;
                if (obs_vec !== exp_vec) begin fails++; $display("FAIL random_model: observed %h expected %h at %0t", obs_vec, exp_vec, $time); end
                bus.clear_i = bus.clear_i ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 79) == 0);
                bus.stop_i  = bus.stop_i  ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
                bus.start_i = bus.start_i ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 14) == 0);
                bus.step_i  = bus.step_i  ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            end
        end
        {bus.clear_i, bus.stop_i, bus.start_i, bus.step_i} = 4'b0000;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.clear_i = 1'b0;
        bus.step_i  = 1'b0;
        bus.div_i   = 24'd3;
        bus.limit_i = 8'd0;
        #10;
        rst = 1'b0;
        #200;
        rst = 1'b1;
        test_reset();
        test_prescaled_run();
        test_pause_step();
        test_limit_done();
        test_wrap();
        test_clear_start_same();
        test_mid_run_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
- Sequencing controller for the N-bit up-counter in Laboratorio 2 (ports clk, rst, EN, Q).
- Turns asynchronous start/stop/clear/step requests into counter control:
  - a rate-limited enable (prescaled from the 10 MHz system clock),
  - a single-cycle counter clear,
  - stop-at-limit.
- Sits between the board push-buttons and the counter instance; reads Q back to detect the limit and wrap.

Parameters:
- N, 8: counter width; must match the counter instance.
- DIV_W, 24: prescaler width.
- SYNC_STAGES, 2: flip-flops per input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock, 10 MHz nominal.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  asynchronous request level; rising edge = start/resume.
- stop_i  in  1  asynchronous request level; rising edge = pause.
- clear_i  in  1  asynchronous request level; rising edge = clear counter, go idle.
- step_i  in  1  asynchronous request level; rising edge = single increment when idle or paused.
- div_i  in  DIV_W  prescaler terminal value; one tick every div_i+1 cycles; quasi-static.
- limit_i  in  N  stop value; 0 = no limit (free-run with wrap).
- q_i  in  N  counter Q feedback.
- en_o  out  1  counter EN.
- clr_no  out  1  active-low counter clear; ANDed with rst externally before the counter rst.
- running_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- wrap_o  out  1  one-cycle pulse when an enabled increment takes q from all-ones to 0.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; prescaler=0; synchronizers and edge registers=0.
  - en_o=0, clr_no=1, running_o=0, done_o=0, wrap_o=0.
- Inputs:
  - Each input passes through SYNC_STAGES flops, then a rising-edge detector (previous-value register); no debounce.
  - The state register acts on the (SYNC_STAGES+1)-th rising clk edge after the input is sampled high; that is the 3rd edge with the default SYNC_STAGES=2.
  - Each press produces exactly one event; a held level produces nothing further.
- Event priority in one cycle: clear > stop > start > step. Lower-priority events in that cycle are dropped.
- Prescaler:
  - Counts 0..div_i; tick when count >= div_i, then reloads 0.
  - Forced to 0 on reset, on start acceptance and on clear.
  - With div_i=0, tick every cycle.
  - First tick occurs div_i+1 cycles after the edge on which RUN is entered.
- States:
  - IDLE: start -> RUN; step -> one en_o pulse, stay IDLE.
  - RUN: stop -> PAUSE; q_i==limit_i with limit_i!=0 -> DONE (checked every cycle; en_o suppressed that cycle).
  - PAUSE: start -> RUN (prescaler restarts at 0); step -> one en_o pulse, stay PAUSE.
  - DONE: start ignored; step ignored; only clear or reset leave it.
  - Any state: clear -> IDLE.
- en_o:
  - Combinational from registered state, tick, registered step event and q_i: en_o = (RUN & tick & ~(limit_i!=0 & q_i==limit_i)) | step_event.
  - Never high for more than one consecutive cycle unless div_i=0 in RUN.
- Step:
  - Ignored in RUN and DONE.
  - In IDLE or PAUSE with limit_i!=0 and q_i==limit_i, the step is suppressed and there is no state change.
- clr_no:
  - Registered; low for exactly one cycle, the cycle after the clear event edge.
  - en_o is forced 0 during that cycle.
- wrap_o:
  - Registered; high one cycle after a cycle where en_o=1 and q_i=={N{1}}.
  - Only possible when limit_i=0 or limit_i is above the wrapped range.
- Reset mid-RUN returns to IDLE immediately (async); no pending events survive.
- limit_i or div_i changes while running take effect in the next cycle's comparison; no glitch protection is required.

Test Plan:
- Reset, then rst=1, div_i=3, limit_i=0, pulse start_i -> running_o=1 on 3rd edge; en_o one-cycle pulses every 4 cycles; q_i 0,1,2,... every 400 ns.
- Running, pulse stop_i -> PAUSE; en_o stays 0 for 500 ns, q holds. Pulse step_i twice -> q +2, exactly 2 single-cycle en_o pulses. Pulse start_i -> resumes after 4 cycles.
- limit_i=10, div_i=0, start -> q counts 0..10, then done_o=1 and en_o=0 with q held at 10. start_i and step_i ignored. clear_i -> clr_no low 1 cycle, q=0, IDLE.
- limit_i=0, div_i=0, run 256+ cycles -> q 255->0; wrap_o high exactly one cycle after the en_o pulse taken at q=255.
- start_i and clear_i rise on the same edge while in IDLE -> clear wins: clr_no pulse, state stays IDLE, no en_o.
- rst=0 asserted mid-RUN between clock edges -> all outputs at reset values immediately. After release, holding start_i high from before the release yields one start only.
